arc_seq_ctrl: RTL and testbench

ARC_SEQ_CTRL -- requirements
Module: arc_seq_ctrl

---
 rtl/arc_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_arc_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc_seq_ctrl.sv
// Arc segment sequencer.
// Buffers arc segment commands in a small FIFO and hands them one at a time to
// the interpolator. It tracks the running position from the interpolator step
// pulses, detects segment completion, and watches RUN for a stalled interpolator.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for enableH and a queued command
// LOAD  | pop FIFO head into the command registers and the position
// START | one-cycle change_readyH strobe; clears the arm flag
// RUN   | interpolator drawing; watchdog active; waits for armed draw_overH
// DONE  | one-cycle seg_doneH strobe; seg_cnt advances
// ERR   | watchdog expired; held until abortH or reset
module arc_seq_ctrl #(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        pulse_clk,
    input  logic        sys_rstH,
    input  logic        enableH,
    input  logic        abortH,
    input  logic        seg_validH,
    output logic        seg_readyH,
    input  logic        seg_direct,
    input  logic [15:0] seg_Xs,
    input  logic [15:0] seg_Ys,
    input  logic [15:0] seg_Xe,
    input  logic [15:0] seg_Ye,
    output logic        direct,
    output logic [15:0] Xs,
    output logic [15:0] Ys,
    output logic [15:0] Xe,
    output logic [15:0] Ye,
    output logic        change_readyH,
    input  logic        X_acc,
    input  logic        X_dec,
    input  logic        Y_acc,
    input  logic        Y_dec,
    input  logic        draw_overH,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic        seg_doneH,
    output logic [7:0]  seg_cnt,
    output logic        busyH,
    output logic        errH,
    output logic        step_errH
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [64:0]   mem [DEPTH];
    logic [64:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;
    logic          step_any;
    logic          draw_accept;
    logic          wdog_expire;
    logic          armed;
    logic [15:0]   wdog;
    logic          cr_next;
    logic          done_next;

    // One axis of the position counter; conflicting pulses cancel out.
    function automatic logic [15:0] step_axis(input logic [15:0] p,
                                              input logic        inc,
                                              input logic        dec);
        logic [15:0] r;
        r = p;
        if (inc && !dec)
            r = p + 16'd1;
        else if (dec && !inc)
            r = p - 16'd1;
        return r;
    endfunction

    // FIFO handshake, occupancy and RUN event decode.
    always_comb begin
        push        = seg_validH && seg_readyH && !abortH;
        pop         = (state == LOAD) && !abortH;
        head        = mem[rd_ptr];
        step_any    = X_acc || X_dec || Y_acc || Y_dec;
        draw_accept = (state == RUN) && armed && draw_overH;
        wdog_expire = (state == RUN) && !step_any && (wdog == TIMEOUT - 16'd1);
        if (abortH) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; abort overrides every state.
    always_comb begin
        state_next = state;
        if (abortH) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (enableH && (count != '0) && !errH) state_next = LOAD;
                LOAD:    state_next = START;
                START:   state_next = RUN;
                RUN: begin
                    if (draw_accept)
                        state_next = DONE;
                    else if (wdog_expire)
                        state_next = ERR;
                end
                DONE:    state_next = IDLE;
                ERR:     state_next = ERR;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode; strobes are registered from the next state so they line up with START/DONE.
    always_comb begin
        busyH     = (state != IDLE) || (count != '0);
        cr_next   = (state_next == START);
        done_next = (state_next == DONE);
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seg_readyH <= 1'b1;
        end else begin
            if (abortH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            seg_readyH <= (count_next < CW'(DEPTH));
        end
    end

    // FIFO storage; entries are only meaningful while counted, so no reset is needed.
    always_ff @(posedge pulse_clk) begin
        if (push)
            mem[wr_ptr] <= {seg_direct, seg_Xs, seg_Ys, seg_Xe, seg_Ye};
    end

    // Command registers, held from one LOAD to the next.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            direct <= 1'b0;
            Xs     <= '0;
            Ys     <= '0;
            Xe     <= '0;
            Ye     <= '0;
        end else if (pop) begin
            direct <= head[64];
            Xs     <= head[63:48];
            Ys     <= head[47:32];
            Xe     <= head[31:16];
            Ye     <= head[15:0];
        end
    end

    // Segment start/done strobes and completed-segment counter.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            change_readyH <= 1'b0;
            seg_doneH     <= 1'b0;
            seg_cnt       <= '0;
        end else begin
            change_readyH <= cr_next;
            seg_doneH     <= done_next;
            if (done_next)
                seg_cnt <= seg_cnt + 8'd1;
        end
    end

    // Arm flag blocks a stale draw_overH; watchdog counts idle RUN cycles.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            armed <= 1'b0;
            wdog  <= '0;
        end else if (abortH) begin
            armed <= 1'b0;
            wdog  <= '0;
        end else if (state == START) begin
            armed <= 1'b0;
            wdog  <= '0;
        end else if (state == RUN) begin
            if (!draw_overH)
                armed <= 1'b1;
            wdog <= step_any ? 16'd0 : wdog + 16'd1;
        end
    end

    // Sticky timeout and step-conflict flags.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            errH      <= 1'b0;
            step_errH <= 1'b0;
        end else begin
            if (abortH)
                errH <= 1'b0;
            else if (wdog_expire && !draw_accept)
                errH <= 1'b1;
            if (!pop && ((X_acc && X_dec) || (Y_acc && Y_dec)))
                step_errH <= 1'b1;
        end
    end

    // Running position: reloaded from the segment start on LOAD, stepped otherwise.
    always_ff @(posedge pulse_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (pop) begin
            pos_x <= head[63:48];
            pos_y <= head[47:32];
        end else begin
            pos_x <= step_axis(pos_x, X_acc, X_dec);
            pos_y <= step_axis(pos_y, Y_acc, Y_dec);
        end
    end

endmodule

// File: tb/tb_arc_seq_ctrl.sv
// Scoreboard bench for arc_seq_ctrl: stimulus queues expected commands and
// completions; a monitor checks them on change_readyH / seg_doneH.
module tb_arc_seq_ctrl;

    logic        pulse_clk;
    logic        sys_rstH;
    logic        enableH;
    logic        abortH;
    logic        seg_validH;
    logic        seg_readyH;
    logic        seg_direct;
    logic [15:0] seg_Xs, seg_Ys, seg_Xe, seg_Ye;
    logic        direct;
    logic [15:0] Xs, Ys, Xe, Ye;
    logic        change_readyH;
    logic        X_acc, X_dec, Y_acc, Y_dec;
    logic        draw_overH;
    logic [15:0] pos_x, pos_y;
    logic        seg_doneH;
    logic [7:0]  seg_cnt;
    logic        busyH;
    logic        errH;
    logic        step_errH;

    arc_seq_ctrl #(.DEPTH(4), .TIMEOUT(16'd8)) dut (
        .pulse_clk(pulse_clk), .sys_rstH(sys_rstH), .enableH(enableH), .abortH(abortH),
        .seg_validH(seg_validH), .seg_readyH(seg_readyH), .seg_direct(seg_direct),
        .seg_Xs(seg_Xs), .seg_Ys(seg_Ys), .seg_Xe(seg_Xe), .seg_Ye(seg_Ye),
        .direct(direct), .Xs(Xs), .Ys(Ys), .Xe(Xe), .Ye(Ye),
        .change_readyH(change_readyH),
        .X_acc(X_acc), .X_dec(X_dec), .Y_acc(Y_acc), .Y_dec(Y_dec),
        .draw_overH(draw_overH), .pos_x(pos_x), .pos_y(pos_y),
        .seg_doneH(seg_doneH), .seg_cnt(seg_cnt), .busyH(busyH),
        .errH(errH), .step_errH(step_errH)
    );

    typedef struct packed {
        logic        d;
        logic [15:0] xs;
        logic [15:0] ys;
        logic [15:0] xe;
        logic [15:0] ye;
    } cmd_t;

    typedef struct packed {
        logic [15:0] pos;
        logic [7:0]  cnt;
    } done_t;

    cmd_t  exp_cmd_q[$];
    done_t exp_done_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    initial pulse_clk = 1'b0;
    always #5 pulse_clk = ~pulse_clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge pulse_clk) begin
        if (!sys_rstH) begin
            if (change_readyH) begin
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_change_readyH", 65'd1, 65'd0);
                end else begin
                    cmd_t c;
                    c = exp_cmd_q.pop_front();
                    check("cmd_outputs", {direct, Xs, Ys, Xe, Ye}, c);
                end
            end
            if (seg_doneH) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_seg_doneH", 65'd1, 65'd0);
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    check("done_pos_cnt", {41'd0, pos_x, seg_cnt}, {41'd0, d});
                end
            end
        end
    end

    task automatic tick();
        @(posedge pulse_clk);
        #1;
    endtask

    task automatic push_cmd(input cmd_t c, input bit exp_acc, input bit exp_start,
                            input bit exp_done, input int nsteps);
        done_t d;
        check("seg_readyH", {64'd0, seg_readyH}, {64'd0, exp_acc});
        seg_validH = 1'b1;
        {seg_direct, seg_Xs, seg_Ys, seg_Xe, seg_Ye} = c;
        tick();
        seg_validH = 1'b0;
        if (exp_acc && exp_start) begin
            exp_cmd_q.push_back(c);
            if (exp_done) begin
                exp_cnt = exp_cnt + 8'd1;
                d.pos = c.xs + 16'(nsteps);
                d.cnt = exp_cnt;
                exp_done_q.push_back(d);
            end
        end
    endtask

    task automatic wait_change(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (change_readyH) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("change_readyH_timeout", 65'd0, 65'd1);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (seg_doneH) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("seg_doneH_timeout", 65'd0, 65'd1);
    endtask

    // Interpolator model: nsteps X_acc pulses starting at START, then draw_overH.
    task automatic do_seg(input int nsteps);
        bit ok;
        wait_change(ok);
        if (!ok) return;
        draw_overH = 1'b0;
        X_acc      = 1'b1;
        repeat (nsteps) tick();
        X_acc      = 1'b0;
        draw_overH = 1'b1;
        wait_done(ok);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        cmd_t c;
        bit   ok;
        bit   saw;
        int   n;

        sys_rstH = 1'b1; enableH = 1'b0; abortH = 1'b0; seg_validH = 1'b0;
        seg_direct = 1'b0; seg_Xs = '0; seg_Ys = '0; seg_Xe = '0; seg_Ye = '0;
        X_acc = 1'b0; X_dec = 1'b0; Y_acc = 1'b0; Y_dec = 1'b0; draw_overH = 1'b0;
        repeat (3) tick();
        check("rst_cmd", {direct, Xs, Ys, Xe, Ye}, 65'd0);
        check("rst_flags", {59'd0, change_readyH, seg_doneH, busyH, errH, step_errH, seg_readyH},
              {59'd0, 6'b000001});
        check("rst_pos_cnt", {25'd0, pos_x, pos_y, seg_cnt}, 65'd0);
        sys_rstH = 1'b0;
        tick();

        // Basic segment: start -10, 20 steps forward.
        enableH = 1'b1;
        c = '{d: 1'b1, xs: 16'hFFF6, ys: 16'd0, xe: 16'd10, ye: 16'd0};
        push_cmd(c, 1'b1, 1'b1, 1'b1, 20);
        do_seg(20);
        tick();
        check("basic_pos_x", {49'd0, pos_x}, {49'd0, 16'd10});
        check("basic_seg_cnt", {57'd0, seg_cnt}, {57'd0, 8'd1});
        check("basic_busy", {64'd0, busyH}, 65'd0);

        // Queueing: 4 accepted, 5th refused while full.
        enableH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = '{d: i[0], xs: 16'(100 * i + 7), ys: 16'(i + 1), xe: 16'(200 + i), ye: 16'hF000 + 16'(i)};
            push_cmd(c, (i < 4), 1'b1, 1'b1, 3);
        end
        check("queue_busy", {64'd0, busyH}, 65'd1);
        check("queue_ready_full", {64'd0, seg_readyH}, 65'd0);
        enableH = 1'b1;
        for (int i = 0; i < 4; i++) do_seg(3);
        tick();
        check("queue_seg_cnt", {57'd0, seg_cnt}, {57'd0, exp_cnt});
        check("queue_busy_end", {64'd0, busyH}, 65'd0);

        // Stale draw_overH held high through START must not complete the segment.
        c = '{d: 1'b0, xs: 16'hFF38, ys: 16'd3, xe: 16'd0, ye: 16'd0};
        push_cmd(c, 1'b1, 1'b1, 1'b1, 6);
        draw_overH = 1'b1;
        wait_change(ok);
        X_acc = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (seg_doneH) saw = 1'b1;
        end
        X_acc = 1'b0;
        draw_overH = 1'b0;
        tick();
        if (seg_doneH) saw = 1'b1;
        check("stale_done_ignored", {64'd0, saw}, 65'd0);
        draw_overH = 1'b1;
        wait_done(ok);
        tick();

        // Timeout: no steps, no done.
        draw_overH = 1'b0;
        c = '{d: 1'b1, xs: 16'd1, ys: 16'd2, xe: 16'd3, ye: 16'd4};
        push_cmd(c, 1'b1, 1'b1, 1'b0, 0);
        wait_change(ok);
        n = 0;
        while (!errH && n < 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", 65'(n), 65'd9);
        check("timeout_busy", {64'd0, busyH}, 65'd1);
        abortH = 1'b1;
        seg_validH = 1'b1;
        {seg_direct, seg_Xs, seg_Ys, seg_Xe, seg_Ye} = 65'h1_5555_6666_7777_8888;
        tick();
        abortH = 1'b0;
        seg_validH = 1'b0;
        check("abort_errH", {64'd0, errH}, 65'd0);
        check("abort_busy", {64'd0, busyH}, 65'd0);
        check("abort_keep_cmd", {direct, Xs, Ys, Xe, Ye}, c);
        repeat (5) tick();
        check("abort_seg_cnt", {57'd0, seg_cnt}, {57'd0, exp_cnt});

        // Position wrap, Y step, and conflicting X pulses.
        c = '{d: 1'b0, xs: 16'h7FFF, ys: 16'd5, xe: 16'd0, ye: 16'd0};
        push_cmd(c, 1'b1, 1'b1, 1'b1, 1);
        wait_change(ok);
        check("wrap_load_pos_x", {49'd0, pos_x}, {49'd0, 16'h7FFF});
        X_acc = 1'b1; Y_dec = 1'b1;
        tick();
        check("wrap_pos_x", {49'd0, pos_x}, {49'd0, 16'h8000});
        check("y_dec_pos_y", {49'd0, pos_y}, {49'd0, 16'd4});
        check("step_err_clear", {64'd0, step_errH}, 65'd0);
        X_acc = 1'b1; X_dec = 1'b1; Y_dec = 1'b0;
        tick();
        check("conflict_pos_x", {49'd0, pos_x}, {49'd0, 16'h8000});
        check("conflict_step_err", {64'd0, step_errH}, 65'd1);
        X_acc = 1'b0; X_dec = 1'b0;
        draw_overH = 1'b0;
        tick();
        draw_overH = 1'b1;
        wait_done(ok);
        tick();

        // Reset during RUN with two commands still queued.
        enableH = 1'b0;
        draw_overH = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = '{d: 1'b1, xs: 16'(40 + i), ys: 16'(50 + i), xe: 16'(60 + i), ye: 16'(70 + i)};
            push_cmd(c, 1'b1, (i == 0), 1'b0, 0);
        end
        enableH = 1'b1;
        wait_change(ok);
        X_acc = 1'b1;
        repeat (2) tick();
        X_acc = 1'b0;
        sys_rstH = 1'b1;
        #1;
        check("midrst_cmd", {direct, Xs, Ys, Xe, Ye}, 65'd0);
        check("midrst_flags", {59'd0, change_readyH, seg_doneH, busyH, errH, step_errH, seg_readyH},
              {59'd0, 6'b000001});
        check("midrst_pos_cnt", {25'd0, pos_x, pos_y, seg_cnt}, 65'd0);
        tick();
        sys_rstH = 1'b0;
        exp_cnt = 8'd0;
        repeat (10) tick();
        check("midrst_flushed", {64'd0, busyH}, 65'd0);

        check("cmd_queue_drained", 65'(exp_cmd_q.size()), 65'd0);
        check("done_queue_drained", 65'(exp_done_q.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
